// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative inverse cipher.
// Contents:
//   - AES_NR, AES_BLK_W, AES_KS_W : round count, block width, key-schedule width
//   - state_e                      : control FSM encoding (IDLE / ROUND / DONE)
//   - INV_SBOX                     : 256-entry inverse S-box, entry b at bits [8b : 8b+7]
//   - xtime, gf_mul9/11/13/14      : GF(2^8) helpers
//   - fn_inv_shift_rows, fn_inv_sub_bytes, fn_inv_mix_columns : block transforms
// Blocks are [0:127] with byte k at bits [8k : 8k+7]; bit 8k is the byte MSB.
// Column c holds bytes 4c..4c+3, row r of column c is byte r+4c.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_BLK_W = 128;
   localparam int AES_KS_W  = AES_BLK_W * (AES_NR + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] fn_inv_sbox(input logic [7:0] b);
      return INV_SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9, 11, 13, 14 decomposed into sums of x, x^2, x^3 multiples
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]
   function automatic logic [0:127] fn_inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [0:127] fn_inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         o[8*k +: 8] = fn_inv_sbox(s[8*k +: 8]);
      end
      return o;
   endfunction

   function automatic logic [0:127] fn_inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(4*c)     +: 8];
         a1 = s[8*(4*c + 1) +: 8];
         a2 = s[8*(4*c + 2) +: 8];
         a3 = s[8*(4*c + 3) +: 8];
         o[8*(4*c)     +: 8] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
         o[8*(4*c + 1) +: 8] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
         o[8*(4*c + 2) +: 8] = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
         o[8*(4*c + 3) +: 8] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// Ports:
//   i_state     [0:127] current block state
//   i_round_key [0:127] round key for this round
//   i_last              final round: InvMixColumns is bypassed
//   o_state     [0:127] InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key),
//                       or the value before InvMixColumns when i_last is set
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [0:AES_BLK_W-1] i_state,
   input  logic [0:AES_BLK_W-1] i_round_key,
   input  logic                 i_last,
   output logic [0:AES_BLK_W-1] o_state
);

   logic [0:AES_BLK_W-1] keyed;

   always_comb begin
      keyed   = fn_inv_sub_bytes(fn_inv_shift_rows(i_state)) ^ i_round_key;
      o_state = i_last ? keyed : fn_inv_mix_columns(keyed);
   end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 inverse cipher, one round per clock, one block in flight.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_valid/o_ready input handshake; o_ready is high only in IDLE
//   i_cipher_text   ciphertext block [0:127]
//   i_key_schedule  round keys, rk[r] = bits [128r : 128r+127]; sampled only at accept
//   o_valid/i_ready output handshake; o_valid is high only in DONE
//   o_plain_text    decrypted block, held stable while o_valid is high
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; once raised, o_valid and o_plain_text hold until the transfer occurs.
module aes_decrypt_iterative
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [0:AES_BLK_W-1]         i_cipher_text,
   input  logic [0:AES_BLK_W*(NR+1)-1]  i_key_schedule,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [0:AES_BLK_W-1]         o_plain_text
);

   state_e               fsm_q, fsm_d;
   logic [3:0]           rnd_q, rnd_d;
   logic [0:AES_BLK_W-1] blk_q, blk_d;
   logic [0:AES_KS_W-1]  key_q, key_d;

   logic [0:AES_BLK_W-1] round_key;
   logic [0:AES_BLK_W-1] round_out;
   logic                 last_round;

   // rnd_q * 128 as a bit offset into the held key schedule
   assign round_key  = key_q[{rnd_q, 7'd0} +: AES_BLK_W];
   assign last_round = (rnd_q == 4'd0);

   aes_inv_round u_inv_round (
      .i_state     (blk_q),
      .i_round_key (round_key),
      .i_last      (last_round),
      .o_state     (round_out)
   );

   always_comb begin
      fsm_d = fsm_q;
      rnd_d = rnd_q;
      blk_d = blk_q;
      key_d = key_q;
      case (fsm_q)
         ST_IDLE: begin
            if (i_valid) begin
               key_d = i_key_schedule;
               blk_d = i_cipher_text ^ i_key_schedule[AES_BLK_W*NR +: AES_BLK_W];
               rnd_d = 4'(NR - 1);
               fsm_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            blk_d = round_out;
            if (last_round) begin
               fsm_d = ST_DONE;
            end else begin
               rnd_d = rnd_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= ST_IDLE;
         rnd_q <= 4'd0;
         blk_q <= '0;
         key_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         rnd_q <= rnd_d;
         blk_q <= blk_d;
         key_q <= key_d;
      end
   end

   assign o_ready      = (fsm_q == ST_IDLE);
   assign o_valid      = (fsm_q == ST_DONE);
   assign o_plain_text = blk_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: FIPS-197 vectors, backpressure, busy input,
// mid-operation reset, and a random round trip against a forward-cipher model.
module tb_aes_decrypt_iterative;

   logic          clk;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [0:127]  i_cipher_text;
   logic [0:1407] i_key_schedule;
   logic          o_valid;
   logic          i_ready;
   logic [0:127]  o_plain_text;

   aes_decrypt_iterative dut (
      .clk            (clk),
      .rst            (rst),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_cipher_text  (i_cipher_text),
      .i_key_schedule (i_key_schedule),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_plain_text   (o_plain_text)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [127:0] exp_q[$];
   logic [7:0] sbox [256];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (forward cipher) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, 8'(x));
         end
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [0:1407] expand_key(input logic [0:127] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [0:1407] ks;
      rcon = 8'h01;
      ks = '0;
      for (int i = 0; i < 44; i++) begin
         if (i < 4) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % 4 == 0) begin
               t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
               rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
         end
         ks[32*i +: 32] = w[i];
      end
      return ks;
   endfunction

   function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
      logic [7:0]   st [16];
      logic [7:0]   nx [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [0:127] ct;
      for (int k = 0; k < 16; k++) st[k] = pt[8*k +: 8] ^ ks[8*k +: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int k = 0; k < 16; k++) st[k] = sbox[st[k]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               nx[r + 4*c] = st[r + 4*((c + r) % 4)];
         if (rd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = nx[4*c]; a1 = nx[4*c+1]; a2 = nx[4*c+2]; a3 = nx[4*c+3];
               nx[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               nx[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               nx[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               nx[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int k = 0; k < 16; k++) st[k] = nx[k] ^ ks[128*rd + 8*k +: 8];
      end
      ct = '0;
      for (int k = 0; k < 16; k++) ct[8*k +: 8] = st[k];
      return ct;
   endfunction

   function automatic logic [0:127] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- driver tasks (called at a negedge) ----------------
   // Waits for o_ready, offers one block, returns at the negedge after the accept edge.
   task automatic send_block(input logic [0:127] ct, input logic [0:1407] ks);
      int guard;
      guard = 0;
      while (!o_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!o_ready) chk("ready_timeout", 128'(o_ready), 128'd1);
      i_cipher_text  = ct;
      i_key_schedule = ks;
      i_valid        = 1'b1;
      @(negedge clk);
      i_valid        = 1'b0;
   endtask

   // Called at the negedge after the accept edge; lat = edges after accept until o_valid.
   task automatic wait_valid(output int lat);
      int cnt;
      cnt = 1;
      while (!o_valid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      lat = cnt - 1;
   endtask

   task automatic take_output(input string tag);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk({tag, "_valid_drop"}, 128'(o_valid), 128'd0);
      chk({tag, "_ready_back"}, 128'(o_ready), 128'd1);
   endtask

   // ---------------- test sequence ----------------
   localparam int N_RAND = 1000;

   initial begin : main
      logic [0:1407] ks_c1, ks_b, ks_x;
      logic [0:127]  pt_a, pt_x, ct_a, ct_x;
      int lat;
      int n_rx;
      int cyc;

      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_cipher_text = '0;
      i_key_schedule = '0;
      build_sbox();

      ks_c1 = expand_key(128'h000102030405060708090a0b0c0d0e0f);
      ks_b  = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("model_c1_rk10", ks_c1[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("model_c1_enc", encrypt(128'h00112233445566778899aabbccddeeff, ks_c1),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(o_ready), 128'd1);
      chk("rst_valid", 128'(o_valid), 128'd0);
      chk("rst_pt", o_plain_text, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 128'(o_ready), 128'd1);

      // FIPS-197 C.1 with exact latency
      send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ks_c1);
      chk("c1_busy_ready", 128'(o_ready), 128'd0);
      wait_valid(lat);
      chk("c1_latency", 128'(lat), 128'd10);
      chk("c1_pt", o_plain_text, 128'h00112233445566778899aabbccddeeff);
      take_output("c1");

      // Appendix B with a five-cycle stall
      send_block(128'h3925841d02dc09fbdc118597196a0b32, ks_b);
      wait_valid(lat);
      chk("b_latency", 128'(lat), 128'd10);
      repeat (5) begin
         chk("b_stall_pt", o_plain_text, 128'h3243f6a8885a308d313198a2e0370734);
         chk("b_stall_ready", 128'(o_ready), 128'd0);
         chk("b_stall_valid", 128'(o_valid), 128'd1);
         @(negedge clk);
      end
      chk("b_pt", o_plain_text, 128'h3243f6a8885a308d313198a2e0370734);
      take_output("b");

      // busy input: a second block offered throughout the first one
      pt_a = rand128();
      ks_x = expand_key(rand128());
      ct_a = encrypt(pt_a, ks_x);
      pt_x = rand128();
      ks_b = expand_key(rand128());
      ct_x = encrypt(pt_x, ks_b);
      send_block(ct_a, ks_x);
      i_cipher_text  = ct_x;
      i_key_schedule = ks_b;
      i_valid        = 1'b1;
      lat = 1;
      while (!o_valid && lat < 50) begin
         chk("busy_ready", 128'(o_ready), 128'd0);
         @(negedge clk);
         lat++;
      end
      chk("busy_latency", 128'(lat - 1), 128'd10);
      chk("busy_pt_first", o_plain_text, pt_a);
      chk("busy_done_ready", 128'(o_ready), 128'd0);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk("busy_hs_valid", 128'(o_valid), 128'd0);
      chk("busy_hs_ready", 128'(o_ready), 128'd1);
      @(negedge clk);
      i_valid = 1'b0;
      chk("busy_second_accept", 128'(o_ready), 128'd0);
      wait_valid(lat);
      chk("busy_second_latency", 128'(lat), 128'd10);
      chk("busy_pt_second", o_plain_text, pt_x);
      take_output("busy");

      // reset in the middle of a block
      send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ks_c1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 128'(o_valid), 128'd0);
      chk("mid_rst_ready", 128'(o_ready), 128'd1);
      chk("mid_rst_pt", o_plain_text, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 128'(o_ready), 128'd1);
      chk("post_rst_valid", 128'(o_valid), 128'd0);
      send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ks_c1);
      wait_valid(lat);
      chk("post_rst_latency", 128'(lat), 128'd10);
      chk("post_rst_pt", o_plain_text, 128'h00112233445566778899aabbccddeeff);
      take_output("post_rst");

      // random round trip with gaps on both sides
      n_rx = 0;
      cyc  = 0;
      fork
         begin : drive
            logic [0:127]  r_pt;
            logic [0:1407] r_ks;
            int guard;
            for (int i = 0; i < N_RAND; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               r_pt = rand128();
               r_ks = expand_key(rand128());
               i_cipher_text  = encrypt(r_pt, r_ks);
               i_key_schedule = r_ks;
               i_valid = 1'b1;
               guard = 0;
               while (!o_ready && guard < 200) begin
                  @(negedge clk);
                  guard++;
               end
               exp_q.push_back(r_pt);
               @(negedge clk);
               i_valid = 1'b0;
            end
         end
         begin : monitor
            while (n_rx < N_RAND && cyc < 60000) begin
               @(negedge clk);
               cyc++;
               i_ready = 1'($urandom_range(0, 1));
               if (o_valid && i_ready) begin
                  if (exp_q.size() == 0) chk("rand_extra", 128'd1, 128'd0);
                  else chk("rand_pt", o_plain_text, exp_q.pop_front());
                  n_rx++;
               end
            end
         end
      join
      @(negedge clk);
      i_ready = 1'b0;
      chk("rand_count", 128'(n_rx), 128'(N_RAND));
      chk("rand_leftover", 128'(exp_q.size()), 128'd0);
      repeat (3) @(negedge clk);
      chk("rand_no_dup", 128'(o_valid), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_iterative.md
# aes_decrypt_iterative

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that takes one 128-bit ciphertext block plus a precomputed 11-round-key schedule and returns the plaintext block. It is the decryption counterpart to the encrypt pipeline stages. It reuses the same 1408-bit key-schedule bus layout, so one key-expansion unit can feed both directions. It trades throughput for area: one round per clock, one block in flight, valid/ready handshakes on both sides.

## Interface
- NR, default 10: number of cipher rounds. Only 10 is legal. The key-schedule width is 128*(NR+1).
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input block offered
- o_ready  out  1  block can be accepted; high only in IDLE
- i_cipher_text  in  [0:127]  ciphertext block; bit 0 is the MSB of byte 0
- i_key_schedule  in  [0:1407]  round keys; rk[r] = bits [128*r : 128*r+127], with rk[0] the cipher key
- o_valid  out  1  plaintext available
- i_ready  in  1  downstream accepts the plaintext
- o_plain_text  out  [0:127]  decrypted block; valid while o_valid is high

## Operation
- States: IDLE, ROUND, DONE. The state is encoded as an enum.
- IDLE:
  - o_ready=1 and o_valid=0.
  - On i_valid && o_ready, latch i_key_schedule into an internal register.
  - Load state <= i_cipher_text ^ rk[NR].
  - Set round counter r <= NR-1 and go to ROUND.
- ROUND, for r = NR-1 down to 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]), then r <= r-1.
- ROUND with r = 0:
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]. InvMixColumns is skipped.
  - Go to DONE.
- DONE:
  - o_valid=1 and o_plain_text = state.
  - On i_ready, go to IDLE.
  - While i_ready is low, o_plain_text is held bit-stable.
- Input changes while in ROUND or DONE are ignored. i_key_schedule is only sampled at acceptance.
- Round counter: 4 bits, unsigned. It never wraps below 0; leaving ROUND happens at r=0.
- Byte order: state byte k = bits [8k : 8k+7]. Columns are bytes 4c..4c+3, as in FIPS-197.

## Timing
- Reset values:
  - State = IDLE.
  - o_ready=1, o_valid=0.
  - o_plain_text = 128'h0.
  - Round counter = 0 and key register = 0.
- Acceptance edge T; o_valid rises after edge T+NR (T+10). Latency is 10 cycles from accept to output.
- Minimum initiation interval is 12 cycles: 1 accept cycle, 10 rounds, and 1 DONE cycle with i_ready=1. The next accept can occur in the cycle after the output handshake.
- o_ready is a decode of the state register, with no combinational path from i_valid or i_ready.
- Reset asserted mid-operation:
  - Outputs go to their reset values immediately (asynchronously).
  - The in-flight block is discarded.
  - The first edge after deassertion is a normal IDLE cycle.
- If i_valid and i_ready are both high in DONE, only the output handshake completes. The input is not accepted until IDLE.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry inverse S-box constant;
  - xtime and GF(2^8) multiply-by-9/11/13/14 functions;
  - fn_inv_shift_rows, fn_inv_sub_bytes and fn_inv_mix_columns;
  - the state enum type;
  - the NR, block-width and key-schedule-width constants.
- One combinational sub-module, aes_inv_round:
  - inputs: state [0:127], round key [0:127], i_last;
  - output: next state;
  - i_last bypasses InvMixColumns.
  - The top instantiates it once; the top holds only the FSM, counter and registers.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key schedule from key 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: o_plain_text = 00112233445566778899aabbccddeeff with o_valid rising exactly 10 cycles after accept.
- FIPS-197 Appendix B with backpressure:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32, i_ready held low 5 cycles.
  - Required: plaintext 3243f6a8885a308d313198a2e0370734 held stable and o_ready=0 throughout the stall.
- Busy input:
  - Stimulus: during ROUND, drive i_valid=1 with a different ciphertext and key.
  - Required: result still equals the first block; o_ready stays 0 until after the output handshake.
- Reset mid-operation:
  - Stimulus: assert rst at round 5.
  - Required: o_valid=0 and o_ready=1 immediately. After release, the C.1 vector decrypts correctly.
- Random round-trip:
  - Stimulus: 1000 random key/plaintext pairs encrypted by a reference model, with random i_valid and i_ready gaps.
  - Required: every output matches, in order, with none dropped or duplicated.
